// File: rtl/avalon_burst_demux_if.sv
// Bundles the master-side and slave-side Avalon-MM signals of the burst demux.
// The slave modport is the demux's view; the master modport is the environment's view.
interface avalon_burst_demux_if #(
  parameter int unsigned NUM_OUTPUTS = 4
);
  logic [29:0]               i_AVIn_Addr;
  logic [3:0]                i_AVIn_ByteEn;
  logic                      i_AVIn_Read;
  logic [31:0]               o_AVIn_ReadData;
  logic                      i_AVIn_Write;
  logic [31:0]               i_AVIn_WriteData;
  logic                      o_AVIn_WaitRequest;
  logic [7:0]                i_AVIn_BurstCount;
  logic [30*NUM_OUTPUTS-1:0] o_AVOut_Addr;
  logic [4*NUM_OUTPUTS-1:0]  o_AVOut_ByteEn;
  logic [NUM_OUTPUTS-1:0]    o_AVOut_Read;
  logic [32*NUM_OUTPUTS-1:0] i_AVOut_ReadData;
  logic [NUM_OUTPUTS-1:0]    o_AVOut_Write;
  logic [32*NUM_OUTPUTS-1:0] o_AVOut_WriteData;
  logic [NUM_OUTPUTS-1:0]    i_AVOut_WaitRequest;
  logic [8*NUM_OUTPUTS-1:0]  o_AVOut_BurstCount;
  logic                      o_DecodeErr;

  modport slave (
    input  i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write,
    input  i_AVIn_WriteData, i_AVIn_BurstCount,
    output o_AVIn_ReadData, o_AVIn_WaitRequest,
    output o_AVOut_Addr, o_AVOut_ByteEn, o_AVOut_Read, o_AVOut_Write,
    output o_AVOut_WriteData, o_AVOut_BurstCount,
    input  i_AVOut_ReadData, i_AVOut_WaitRequest,
    output o_DecodeErr
  );

  modport master (
    output i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_Read, i_AVIn_Write,
    output i_AVIn_WriteData, i_AVIn_BurstCount,
    input  o_AVIn_ReadData, o_AVIn_WaitRequest,
    input  o_AVOut_Addr, o_AVOut_ByteEn, o_AVOut_Read, o_AVOut_Write,
    input  o_AVOut_WriteData, o_AVOut_BurstCount,
    output i_AVOut_ReadData, i_AVOut_WaitRequest,
    input  o_DecodeErr
  );
endinterface

// File: rtl/avalon_burst_demux.sv
// Avalon-MM 1-to-N demux: steers each transaction by upper address bits, holds the slave for a burst.
// Zero added latency on the request path; master stalls on the owning slave's waitrequest, decode errors cost one cycle.
module avalon_burst_demux #(
  parameter int unsigned NUM_OUTPUTS   = 4,
  parameter int unsigned NUM_SEL_BITS  = 5,
  parameter int unsigned SEL_BASE      = 0,
  parameter logic [31:0] ERR_READ_DATA = 32'hDEADBEEF
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  avalon_burst_demux_if.slave    bus
);

  localparam int unsigned SEL_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    ERR   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [7:0]        beats_left_q, beats_left_d;

  logic [NUM_SEL_BITS-1:0] sel_field;
  logic                    sel_valid;
  logic [SEL_W-1:0]        dec_sel;
  logic [SEL_W-1:0]        route_sel;
  logic                    route_en;
  logic                    req;
  logic                    slave_wait;
  logic [31:0]             slave_rdata;
  logic                    accept;

  logic [NUM_OUTPUTS-1:0]  out_read;
  logic [NUM_OUTPUTS-1:0]  out_write;
  logic                    in_wait;
  logic [31:0]             in_rdata;
  logic                    decode_err;

  assign req       = bus.i_AVIn_Read | bus.i_AVIn_Write;
  assign sel_field = bus.i_AVIn_Addr[29 -: NUM_SEL_BITS];

  always_comb begin
    sel_valid = 1'b0;
    dec_sel   = '0;
    for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
      if (32'(sel_field) == SEL_BASE + k) begin
        sel_valid = 1'b1;
        dec_sel   = SEL_W'(k);
      end
    end
  end

  // Mid-burst the latched owner wins, so address changes cannot re-steer the burst.
  assign route_sel = (state_q == BURST) ? sel_q : dec_sel;
  assign route_en  = i_Rst_n && (((state_q == IDLE) && sel_valid) || (state_q == BURST));

  always_comb begin
    slave_wait  = 1'b1;
    slave_rdata = '0;
    for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
      if (SEL_W'(k) == route_sel) begin
        slave_wait  = bus.i_AVOut_WaitRequest[k];
        slave_rdata = bus.i_AVOut_ReadData[32*k +: 32];
      end
    end
  end

  always_comb begin
    out_read   = '0;
    out_write  = '0;
    in_wait    = 1'b1;
    in_rdata   = '0;
    decode_err = 1'b0;
    if (route_en && req) begin
      in_wait  = slave_wait;
      in_rdata = slave_rdata;
      for (int unsigned k = 0; k < NUM_OUTPUTS; k++) begin
        if (SEL_W'(k) == route_sel) begin
          out_write[k] = bus.i_AVIn_Write;
          out_read[k]  = bus.i_AVIn_Read & ~bus.i_AVIn_Write;
        end
      end
    end else if (i_Rst_n && (state_q == ERR) && req) begin
      in_wait    = 1'b0;
      in_rdata   = ERR_READ_DATA;
      decode_err = 1'b1;
    end
  end

  assign accept = route_en && req && !slave_wait;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (sel_valid) begin
            if (accept && (bus.i_AVIn_BurstCount > 8'd1)) begin
              state_d      = BURST;
              sel_d        = dec_sel;
              beats_left_d = bus.i_AVIn_BurstCount - 8'd1;
            end
          end else begin
            state_d      = ERR;
            beats_left_d = (bus.i_AVIn_BurstCount == 8'd0) ? 8'd1 : bus.i_AVIn_BurstCount;
          end
        end
      end
      BURST: begin
        if (accept) begin
          beats_left_d = beats_left_q - 8'd1;
          if (beats_left_q == 8'd1) state_d = IDLE;
        end
      end
      ERR: begin
        if (req) begin
          beats_left_d = beats_left_q - 8'd1;
          if (beats_left_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      beats_left_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      beats_left_q <= beats_left_d;
    end
  end

  assign bus.o_AVOut_Addr       = {NUM_OUTPUTS{bus.i_AVIn_Addr}};
  assign bus.o_AVOut_ByteEn     = {NUM_OUTPUTS{bus.i_AVIn_ByteEn}};
  assign bus.o_AVOut_WriteData  = {NUM_OUTPUTS{bus.i_AVIn_WriteData}};
  assign bus.o_AVOut_BurstCount = {NUM_OUTPUTS{bus.i_AVIn_BurstCount}};
  assign bus.o_AVOut_Read       = out_read;
  assign bus.o_AVOut_Write      = out_write;
  assign bus.o_AVIn_WaitRequest = in_wait;
  assign bus.o_AVIn_ReadData    = in_rdata;
  assign bus.o_DecodeErr        = decode_err;

endmodule

// File: doc/avalon_burst_demux.md
Name: avalon_burst_demux

Overview:
- One Avalon-MM master bus fans out to NUM_OUTPUTS slave buses. This block is the one-to-many counterpart of the many-to-one AvalonMux.
- Each transaction is steered by a decode of the upper address bits.
- The slave selection is held for the whole of a multi-beat burst.
- Read data and waitrequest return from the slave that owns the transaction.
- Addresses that decode to no slave complete with an error response, so the master never hangs.

Parameters:
NUM_OUTPUTS, 4, number of slave ports (1..32)
NUM_SEL_BITS, 5, width of the select field, taken from i_AVIn_Addr[29 -: NUM_SEL_BITS]
SEL_BASE, 0, select value that maps to slave 0; slave k is selected by SEL_BASE+k
ERR_READ_DATA, 32'hDEADBEEF, read data returned on a decode error

Ports:
i_Clk  in  1  clock
i_Rst_n  in  1  asynchronous active-low reset
i_AVIn_Addr  in  30  master word address
i_AVIn_ByteEn  in  4  byte enables
i_AVIn_Read  in  1  read request
o_AVIn_ReadData  out  32  read data
i_AVIn_Write  in  1  write request
i_AVIn_WriteData  in  32  write data
o_AVIn_WaitRequest  out  1  stall
i_AVIn_BurstCount  in  8  burst length in beats
o_AVOut_Addr  out  30*NUM_OUTPUTS  address, broadcast to all slaves
o_AVOut_ByteEn  out  4*NUM_OUTPUTS  byte enables, broadcast
o_AVOut_Read  out  NUM_OUTPUTS  per-slave read, at most one bit set
i_AVOut_ReadData  in  32*NUM_OUTPUTS  per-slave read data
o_AVOut_Write  out  NUM_OUTPUTS  per-slave write, at most one bit set
o_AVOut_WriteData  out  32*NUM_OUTPUTS  write data, broadcast
i_AVOut_WaitRequest  in  NUM_OUTPUTS  per-slave stall
o_AVOut_BurstCount  out  8*NUM_OUTPUTS  burst count, broadcast
o_DecodeErr  out  1  one-cycle pulse on each errored beat

Behaviour:
- Reset (async assert, sync release): r_State=IDLE, r_Sel=0, r_BeatsLeft=0, o_DecodeErr=0. While i_Rst_n=0, o_AVOut_Read/o_AVOut_Write=0 and o_AVIn_WaitRequest=1.
- Beat accepted: a cycle in which (Read|Write) is high and the selected WaitRequest is low. Read data is valid in that same cycle (no readdatavalid signal). Read and Write asserted together is illegal; if it happens, Write has priority.
- Decode (IDLE): sel = Addr[29 -: NUM_SEL_BITS] - SEL_BASE, evaluated combinationally. Valid when SEL_BASE <= field < SEL_BASE+NUM_OUTPUTS.
- Slave request gating: Read/Write are forwarded only to slave sel. All other slaves see 0.
- Master return path: o_AVIn_WaitRequest = i_AVOut_WaitRequest[sel] and o_AVIn_ReadData = i_AVOut_ReadData[sel].
- No request pending: o_AVIn_WaitRequest=1 and o_AVIn_ReadData=0.
- States: IDLE, BURST, ERR.
- IDLE, valid select:
  - BurstCount is 0 or 1: single beat, stay in IDLE.
  - BurstCount=N>1 with first beat accepted: r_Sel<=sel, r_BeatsLeft<=N-1, go to BURST.
- BURST:
  - Routing uses r_Sel and ignores the address decode (the address may change mid-burst).
  - Each accepted beat decrements r_BeatsLeft.
  - Acceptance with r_BeatsLeft==1 returns to IDLE. The next cycle decodes afresh, with no bubble required.
  - Read and Write both dropping mid-burst: hold state and wait. A burst is never aborted except by reset.
- IDLE, invalid select: go to ERR with r_BeatsLeft<=max(BurstCount,1).
- ERR:
  - Each cycle with a request present: o_AVIn_WaitRequest=0, o_AVIn_ReadData=ERR_READ_DATA, o_DecodeErr=1, r_BeatsLeft decrements.
  - The write is discarded, and no slave sees a request.
  - Return to IDLE after the last beat.
  - The IDLE cycle on entry holds WaitRequest=1, so error latency is 1 cycle per transaction.
- Reset mid-burst: the state machine returns to IDLE immediately and slave requests drop asynchronously.
- BurstCount=255: the counter is 8 bits and does not wrap. Exactly 255 beats are transferred.
- Implementation: r_BeatsLeft is 8 bits; the sel mux is a parameterised loop. Expected size is roughly 150-250 lines.

Test Plan:
- Single write, Addr={5'd2,25'h3}, Data=32'h1, BurstCount=1, slave 2 WaitRequest 1 cycle -> only o_AVOut_Write[2] high; o_AVIn_WaitRequest low on the 2nd cycle; state stays IDLE.
- Burst read of 4 beats to slave 1 (3 wait cycles per beat); master changes the address select field to 3 after beat 1 -> all 4 beats routed to slave 1; o_AVOut_Read[3] never high; ReadData equals slave 1 data on each accept.
- Address select 5'd20 with NUM_OUTPUTS=4, read, BurstCount=2 -> no slave request; two accepted beats each returning 32'hDEADBEEF; o_DecodeErr pulses twice; back to IDLE.
- Back-to-back bursts: 2-beat write to slave 0 immediately followed by a 1-beat read to slave 3 -> read routed to slave 3 in the cycle after the last write accept.
- i_Rst_n pulled low during beat 2 of a 4-beat write -> o_AVOut_Write all 0 at once; o_AVIn_WaitRequest=1; after release, a new write to slave 1 decodes normally.
- BurstCount=0 write to slave 0 -> treated as a single beat; state never enters BURST.
